// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-stage definitions: exception codes, reset PC and FSM state encoding.
package if_fetch_queue_pkg;

  localparam int unsigned EXC_CODE_W = 5;

  localparam logic [EXC_CODE_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] PC_INIT_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    MISALIGN = 2'd1,
    HALT     = 2'd2
  } fetch_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Small synchronous FIFO with clear. Clear outranks push/pop; a push on a full
// FIFO is accepted when it is paired with a pop in the same cycle.
module fetch_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generation, pipelined imem requests and a squashable
// decode-facing queue. Define FETCH_PERF_EN to add perf_redirects/perf_starve.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       DEPTH   = 4,
  parameter int unsigned       MAX_OUT = 2,
  parameter logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_INIT_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_flush,
  input  logic [ADDR_W-1:0]     exc_addr,
  input  logic                  br_valid,
  input  logic [ADDR_W-1:0]     br_addr,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_W-1:0]     imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_pc,
  output logic [ADDR_W-1:0]     out_pc_plus_4,
  output logic [DATA_W-1:0]     out_inst,
  output logic [EXC_CODE_W-1:0] out_exccode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_redirects,
  output logic [31:0]           perf_starve
`endif
);

  localparam int unsigned QCNT_W = cnt_width(DEPTH);
  localparam int unsigned TCNT_W = cnt_width(MAX_OUT);
  localparam int unsigned SUM_W  = cnt_width(DEPTH + MAX_OUT);

  typedef struct packed {
    logic [ADDR_W-1:0]     pc;
    logic [DATA_W-1:0]     inst;
    logic [EXC_CODE_W-1:0] exc;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [TCNT_W-1:0] drop_q, drop_d;

  logic              redirect;
  logic [ADDR_W-1:0] redir_pc;
  logic [SUM_W-1:0]  outstanding, credit_used;
  logic              issue, grant, rsp_live, rsp_drop, adel_push, q_push;
  entry_t            q_wr, q_rd;
  logic [QCNT_W-1:0] q_count;
  logic              q_full, q_empty;
  logic [TCNT_W-1:0] tag_count;
  logic              tag_full, tag_empty;
  logic [ADDR_W-1:0] tag_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // Squashed responses still hold a credit until they return, so drop_q counts as outstanding.
  always_comb begin
    outstanding = SUM_W'(tag_count) + SUM_W'(drop_q);
    credit_used = outstanding + SUM_W'(q_count);
    redirect    = exc_flush || br_valid;
    redir_pc    = exc_flush ? exc_addr : br_addr;
    issue       = !rst && !redirect && (state_q == FETCH) && (pc_q[1:0] == 2'b00) && !tag_full
                  && (outstanding < SUM_W'(MAX_OUT)) && (credit_used < SUM_W'(DEPTH));
    grant       = issue && imem_gnt;
    rsp_live    = imem_rvalid && (drop_q == '0) && !tag_empty;
    rsp_drop    = imem_rvalid && (drop_q != '0);
    adel_push   = (state_q == MISALIGN) && (outstanding == '0) && !q_full && !redirect;
    q_push      = rsp_live || adel_push;
    q_wr.pc     = rsp_live ? tag_pc : pc_q;
    q_wr.inst   = rsp_live ? imem_rdata : '0;
    q_wr.exc    = rsp_live ? EXC_NONE : EXC_ADEL;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redirect) begin
      state_d = FETCH;
      pc_d    = redir_pc;
      drop_d  = TCNT_W'(outstanding - SUM_W'(rsp_live || rsp_drop));
    end else begin
      if (grant) pc_d = pc_q + ADDR_W'(4);
      if (rsp_drop) drop_d = drop_q - TCNT_W'(1);
      unique case (state_q)
        FETCH:    if (pc_q[1:0] != 2'b00) state_d = MISALIGN;
        MISALIGN: if (adel_push) state_d = HALT;
        HALT:     state_d = HALT;
        default:  state_d = FETCH;
      endcase
    end
  end

  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (out_valid && out_ready),
    .clear (redirect),
    .wdata (q_wr),
    .rdata (q_rd),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (rsp_live),
    .clear (redirect),
    .wdata (pc_q),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign imem_req      = issue;
  assign imem_addr     = pc_q;
  assign out_valid     = !q_empty;
  assign out_pc        = q_rd.pc;
  assign out_pc_plus_4 = q_rd.pc + ADDR_W'(4);
  assign out_inst      = (q_rd.exc != EXC_NONE) ? '0 : q_rd.inst;
  assign out_exccode   = q_rd.exc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_starve_q, perf_starve_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q + 32'(redirect);
    perf_starve_d    = perf_starve_q + 32'(q_empty && (state_q != HALT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects_q <= '0;
      perf_starve_q    <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_starve_q    <= perf_starve_d;
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_starve    = perf_starve_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a variable-latency in-order memory model.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        exc_flush;
  logic [31:0] exc_addr;
  logic        br_valid;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_inst;
  logic [4:0]  out_exccode;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_starve;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 1;

  localparam logic [4:0] X_NONE = 5'd0;
  localparam logic [4:0] X_ADEL = 5'd4;

  if_fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .exc_flush     (exc_flush),
    .exc_addr      (exc_addr),
    .br_valid      (br_valid),
    .br_addr       (br_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_inst      (out_inst),
    .out_exccode   (out_exccode)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects(perf_redirects),
    .perf_starve   (perf_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a;
  endfunction

  // Memory model: a grant at edge k returns its word sampled at edge k+lat.
  logic        dl_v [0:7];
  logic [31:0] dl_a [0:7];
  initial imem_rvalid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) dl_v[i] <= 1'b0;
      imem_rvalid <= 1'b0;
    end else begin
      if (imem_req && imem_gnt && lat == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= inst_of(imem_addr);
      end else begin
        imem_rvalid <= dl_v[0];
        imem_rdata  <= inst_of(dl_a[0]);
      end
      for (int i = 0; i < 7; i++) begin
        if (imem_req && imem_gnt && i == lat - 2) begin
          dl_v[i] <= 1'b1;
          dl_a[i] <= imem_addr;
        end else begin
          dl_v[i] <= dl_v[i+1];
          dl_a[i] <= dl_a[i+1];
        end
      end
      dl_v[7] <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a valid head, check all its fields, then step one cycle.
  task automatic expect_head(input string tag, input int budget, input logic [31:0] pc,
                             input logic [31:0] inst, input logic [4:0] exc);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".pc"},    64'(out_pc), 64'(pc));
    check({tag, ".pc4"},   64'(out_pc_plus_4), 64'(pc + 32'd4));
    check({tag, ".inst"},  64'(out_inst), 64'(inst));
    check({tag, ".exc"},   64'(out_exccode), 64'(exc));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; exc_flush = 1'b0; exc_addr = '0; br_valid = 1'b0; br_addr = '0;
    imem_gnt = 1'b0; out_ready = 1'b0; lat = 1;
    repeat (2) @(negedge clk);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.imem_req",  64'(imem_req), 64'd0);
    check("rst.imem_addr", 64'(imem_addr), 64'h0000_0000_BFC0_0000);

    // Streaming with 1-cycle memory: consecutive PCs on consecutive cycles.
    rst = 1'b0; imem_gnt = 1'b1; out_ready = 1'b1;
    expect_head("t1_h0", 10, 32'hBFC0_0000, inst_of(32'hBFC0_0000), X_NONE);
    expect_head("t1_h1", 0,  32'hBFC0_0004, inst_of(32'hBFC0_0004), X_NONE);
    check("t1_h2.valid", 64'(out_valid), 64'd1);
    check("t1_h2.pc",    64'(out_pc), 64'h0000_0000_BFC0_0008);

    // Backpressure: queue fills to DEPTH and requests stop.
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("t2.imem_req_stall", 64'(imem_req), 64'd0);
    check("t2.head_held",      64'(out_pc), 64'h0000_0000_BFC0_0008);
    imem_gnt = 1'b0; out_ready = 1'b1;
    expect_head("t2_h0", 0, 32'hBFC0_0008, inst_of(32'hBFC0_0008), X_NONE);
    expect_head("t2_h1", 0, 32'hBFC0_000C, inst_of(32'hBFC0_000C), X_NONE);
    expect_head("t2_h2", 0, 32'hBFC0_0010, inst_of(32'hBFC0_0010), X_NONE);
    expect_head("t2_h3", 0, 32'hBFC0_0014, inst_of(32'hBFC0_0014), X_NONE);
    check("t2.drained",   64'(out_valid), 64'd0);
    check("t2.req_next",  64'(imem_req), 64'd1);
    check("t2.addr_next", 64'(imem_addr), 64'h0000_0000_BFC0_0018);

    // Branch with two latency-3 requests in flight: both responses squashed.
    lat = 3; imem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3.max_out", 64'(imem_req), 64'd0);
    br_valid = 1'b1; br_addr = 32'h8000_1000;
    @(negedge clk);
    br_valid = 1'b0;
    check("t3.flushed", 64'(out_valid), 64'd0);
    expect_head("t3_h0", 20, 32'h8000_1000, inst_of(32'h8000_1000), X_NONE);
    expect_head("t3_h1", 20, 32'h8000_1004, inst_of(32'h8000_1004), X_NONE);

    // Exception flush outranks a simultaneous branch.
    exc_flush = 1'b1; exc_addr = 32'hBFC0_0380; br_valid = 1'b1; br_addr = 32'h8000_5000;
    @(negedge clk);
    exc_flush = 1'b0; br_valid = 1'b0;
    expect_head("t4_h0", 20, 32'hBFC0_0380, inst_of(32'hBFC0_0380), X_NONE);
    expect_head("t4_h1", 20, 32'hBFC0_0384, inst_of(32'hBFC0_0384), X_NONE);

    // Misaligned branch target: one AdEL entry, then halt until redirected.
    imem_gnt = 1'b0;
    repeat (6) @(negedge clk);
    lat = 1; imem_gnt = 1'b1;
    br_valid = 1'b1; br_addr = 32'h8000_0002;
    @(negedge clk);
    br_valid = 1'b0;
    check("t5.no_req", 64'(imem_req), 64'd0);
    expect_head("t5_adel", 10, 32'h8000_0002, 32'h0, X_ADEL);
    repeat (5) @(negedge clk);
    check("t5.halt_valid", 64'(out_valid), 64'd0);
    check("t5.halt_req",   64'(imem_req), 64'd0);
    br_valid = 1'b1; br_addr = 32'h8000_2000;
    @(negedge clk);
    br_valid = 1'b0;
    expect_head("t5_resume", 10, 32'h8000_2000, inst_of(32'h8000_2000), X_NONE);

    // Reset in the middle of a burst with entries queued.
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("t6.queued", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6.out_valid", 64'(out_valid), 64'd0);
    check("t6.imem_req",  64'(imem_req), 64'd0);
    check("t6.pc_init",   64'(imem_addr), 64'h0000_0000_BFC0_0000);
    rst = 1'b0; out_ready = 1'b1;
    expect_head("t6_h0", 10, 32'hBFC0_0000, inst_of(32'hBFC0_0000), X_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
